// File: rtl/box_plotter.sv
// Rectangle pixel-stream generator for the 160x120 VGA adapter: latches a box on start
// and emits one registered pixel per clock in raster order, with clipping and a done pulse.
module box_plotter #(
  parameter int unsigned SCREEN_W  = 160,
  parameter int unsigned SCREEN_H  = 120,
  parameter int unsigned SIZE_W    = 5,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              erase,
  input  logic [7:0]        x0,
  input  logic [7:0]        y0,
  input  logic [SIZE_W-1:0] w,
  input  logic [SIZE_W-1:0] h,
  input  logic [2:0]        colour,
  output logic [7:0]        x_out,
  output logic [7:0]        y_out,
  output logic [2:0]        colour_out,
  output logic              plot,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

  localparam logic [SIZE_W-1:0] ONE = SIZE_W'(1);

  state_t            state, state_nxt;
  logic [7:0]        x0_q, y0_q, x0_nxt, y0_nxt;
  logic [SIZE_W-1:0] w_q, h_q, w_nxt, h_nxt;
  logic [SIZE_W-1:0] cx, cy, cx_nxt, cy_nxt;
  logic [2:0]        col_q, col_nxt;
  logic              erase_q, erase_nxt;

  logic [7:0]        x_nxt, y_nxt;
  logic [2:0]        cout_nxt;
  logic              plot_nxt, busy_nxt, done_nxt;

  // Pixel selected for emission on the next edge
  logic              emit;
  logic [7:0]        ex_base, ey_base;
  logic [SIZE_W-1:0] ecx, ecy;
  logic [2:0]        ecol;
  logic [8:0]        xs, ys;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      cx         <= '0;
      cy         <= '0;
      col_q      <= '0;
      erase_q    <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      x0_q       <= x0_nxt;
      y0_q       <= y0_nxt;
      w_q        <= w_nxt;
      h_q        <= h_nxt;
      cx         <= cx_nxt;
      cy         <= cy_nxt;
      col_q      <= col_nxt;
      erase_q    <= erase_nxt;
      x_out      <= x_nxt;
      y_out      <= y_nxt;
      colour_out <= cout_nxt;
      plot       <= plot_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    x0_nxt    = x0_q;
    y0_nxt    = y0_q;
    w_nxt     = w_q;
    h_nxt     = h_q;
    cx_nxt    = cx;
    cy_nxt    = cy;
    col_nxt   = col_q;
    erase_nxt = erase_q;
    x_nxt     = x_out;
    y_nxt     = y_out;
    cout_nxt  = colour_out;
    plot_nxt  = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    emit      = 1'b0;
    ex_base   = x0_q;
    ey_base   = y0_q;
    ecx       = cx;
    ecy       = cy;
    ecol      = erase_q ? BG_COLOUR : col_q;

    unique case (state)
      IDLE: begin
        if (start) begin
          if (w == '0 || h == '0) begin
            state_nxt = FIN;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = SCAN;
            x0_nxt    = x0;
            y0_nxt    = y0;
            w_nxt     = w;
            h_nxt     = h;
            col_nxt   = colour;
            erase_nxt = erase;
            cx_nxt    = '0;
            cy_nxt    = '0;
            busy_nxt  = 1'b1;
            // First pixel comes straight from the inputs so it is visible one cycle after start
            emit      = 1'b1;
            ex_base   = x0;
            ey_base   = y0;
            ecx       = '0;
            ecy       = '0;
            ecol      = erase ? BG_COLOUR : colour;
          end
        end
      end
      SCAN: begin
        if (cx == w_q - ONE && cy == h_q - ONE) begin
          state_nxt = FIN;
          done_nxt  = 1'b1;
        end else begin
          busy_nxt = 1'b1;
          emit     = 1'b1;
          if (cx == w_q - ONE) begin
            cx_nxt = '0;
            cy_nxt = cy + ONE;
          end else begin
            cx_nxt = cx + ONE;
          end
          ecx = cx_nxt;
          ecy = cy_nxt;
        end
      end
      FIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    xs = {1'b0, ex_base} + 9'(ecx);
    ys = {1'b0, ey_base} + 9'(ecy);
    if (emit) begin
      x_nxt    = xs[7:0];
      y_nxt    = ys[7:0];
      cout_nxt = ecol;
      // Carry-out is covered by the 9-bit compare
      plot_nxt = (xs < 9'(SCREEN_W)) && (ys < 9'(SCREEN_H));
    end
  end

endmodule

// File: tb/tb_box_plotter.sv
// Directed self-checking bench for box_plotter: draw, erase, clipping, zero size,
// start while busy, back-to-back start and reset mid-scan.
module tb_box_plotter;

  logic       clk = 1'b0;
  logic       resetn, start, erase;
  logic [7:0] x0, y0;
  logic [4:0] w, h;
  logic [2:0] colour;
  logic [7:0] x_out, y_out;
  logic [2:0] colour_out;
  logic       plot, busy, done;

  int checks = 0;
  int errors = 0;

  box_plotter #(.SCREEN_W(160), .SCREEN_H(120), .SIZE_W(5), .BG_COLOUR(3'b000)) dut (
    .clk(clk), .resetn(resetn), .start(start), .erase(erase),
    .x0(x0), .y0(y0), .w(w), .h(h), .colour(colour),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Starts a box and checks every pixel cycle plus the done cycle; returns at the done cycle.
  // poke >= 0 pulses start with a different x0/w during that pixel index.
  task automatic draw_box(input logic [7:0] bx, input logic [7:0] by, input logic [4:0] bw,
                          input logic [4:0] bh, input logic [2:0] bc, input logic be,
                          input int poke);
    int idx, ex, ey;
    x0 = bx; y0 = by; w = bw; h = bh; colour = bc; erase = be; start = 1'b1;
    for (int j = 0; j < int'(bh); j++) begin
      for (int i = 0; i < int'(bw); i++) begin
        @(negedge clk);
        idx = j * int'(bw) + i;
        if (idx == 0) start = 1'b0;
        if (idx == poke) begin start = 1'b1; x0 = 8'd200; w = 5'd7; end
        if (poke >= 0 && idx == poke + 1) begin start = 1'b0; x0 = bx; w = bw; end
        ex = int'(bx) + i;
        ey = int'(by) + j;
        check("x_out", x_out, 32'(ex & 255));
        check("y_out", y_out, 32'(ey & 255));
        check("plot", plot, (ex < 160 && ey < 120) ? 32'd1 : 32'd0);
        check("colour_out", colour_out, be ? 32'd0 : 32'(bc));
        check("busy", busy, 32'd1);
        check("done_early", done, 32'd0);
      end
    end
    @(negedge clk);
    check("done", done, 32'd1);
    check("busy_at_done", busy, 32'd0);
    check("plot_at_done", plot, 32'd0);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; erase = 1'b0;
    x0 = '0; y0 = '0; w = '0; h = '0; colour = '0;
    repeat (3) @(negedge clk);
    check("rst_x", x_out, 0);
    check("rst_y", y_out, 0);
    check("rst_col", colour_out, 0);
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Basic draw
    draw_box(8'd10, 8'd20, 5'd3, 5'd2, 3'b101, 1'b0, -1);
    @(negedge clk);
    check("done_single", done, 0);
    check("hold_x", x_out, 12);
    check("hold_y", y_out, 21);
    check("idle_plot", plot, 0);

    // Erase: same geometry, background colour
    draw_box(8'd10, 8'd20, 5'd3, 5'd2, 3'b111, 1'b1, -1);
    @(negedge clk);
    check("erase_done_single", done, 0);

    // Clipping at the bottom-right corner
    draw_box(8'd158, 8'd119, 5'd4, 5'd2, 3'b010, 1'b0, -1);
    @(negedge clk);

    // Zero width and zero height
    x0 = 8'd5; y0 = 8'd5; w = 5'd0; h = 5'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zw_done", done, 1);
    check("zw_busy", busy, 0);
    check("zw_plot", plot, 0);
    @(negedge clk);
    check("zw_done_off", done, 0);
    check("zw_busy_off", busy, 0);
    w = 5'd5; h = 5'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zh_done", done, 1);
    check("zh_busy", busy, 0);
    @(negedge clk);

    // Start while busy is ignored; start held across the done cycle begins a new box
    draw_box(8'd30, 8'd40, 5'd4, 5'd4, 3'b011, 1'b0, 4);
    x0 = 8'd50; y0 = 8'd60; w = 5'd2; h = 5'd1; colour = 3'b110; erase = 1'b0; start = 1'b1;
    @(negedge clk);
    check("gap_busy", busy, 0);
    check("gap_plot", plot, 0);
    check("gap_done", done, 0);
    draw_box(8'd50, 8'd60, 5'd2, 5'd1, 3'b110, 1'b0, -1);
    @(negedge clk);

    // Reset during a 5x5 box
    x0 = 8'd70; y0 = 8'd80; w = 5'd5; h = 5'd5; colour = 3'b001; erase = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("r_px0_x", x_out, 70);
    @(negedge clk);
    @(negedge clk);
    check("r_px2_x", x_out, 72);
    check("r_px2_plot", plot, 1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("r_x", x_out, 0);
    check("r_y", y_out, 0);
    check("r_col", colour_out, 0);
    check("r_plot", plot, 0);
    check("r_busy", busy, 0);
    check("r_done", done, 0);
    repeat (3) begin
      @(negedge clk);
      check("r_no_done", done, 0);
      check("r_no_plot", plot, 0);
    end
    draw_box(8'd10, 8'd20, 5'd3, 5'd2, 3'b101, 1'b0, -1);
    @(negedge clk);
    check("final_done_off", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
